// File: rtl/sisc_arb_pkg.sv
// Shared constants and types for the SISC result-bus arbiter.
package sisc_arb_pkg;

   localparam int unsigned NREQ_DFLT      = 4;
   localparam int unsigned DW_DFLT        = 4;
   localparam int unsigned MAX_BURST_DFLT = 4;
   localparam int unsigned SRC_W          = 2;
   localparam int unsigned BCNT_W         = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Source of the next bus_data value.
   typedef enum logic [1:0] {
      DSEL_HOLD  = 2'd0,
      DSEL_OWNER = 2'd1,
      DSEL_WIN   = 2'd2
   } dsel_e;

   function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
      return idx + SRC_W'(1);
   endfunction

endpackage

// File: rtl/mux4.sv
// Generic 4:1 select cell used to build the bus select trees.
module mux4 #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   input  logic [1:0]   sel,
   output logic [W-1:0] y
);

   always_comb begin
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first set request scanning from ptr upward, modulo 4.
module rr_priority_pick
   import sisc_arb_pkg::*;
(
   input  logic [3:0]       req,
   input  logic [SRC_W-1:0] ptr,
   output logic             any,
   output logic [SRC_W-1:0] winner
);

   logic [3:0]       rot;
   logic [SRC_W-1:0] off;

   // Rotate so bit 0 is the highest-priority requester, then take the lowest set bit.
   always_comb begin
      rot = 4'({req, req} >> ptr);
      off = '0;
      for (int i = 3; i >= 0; i--) begin
         if (rot[i]) off = SRC_W'(i);
      end
   end

   assign any    = |req;
   assign winner = ptr + off;

endmodule

// File: rtl/nibble_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4-bit SISC result bus,
// with per-requester burst lock and consumer backpressure.
module nibble_bus_arbiter
   import sisc_arb_pkg::*;
#(
   parameter int unsigned NREQ      = NREQ_DFLT,
   parameter int unsigned DW        = DW_DFLT,
   parameter int unsigned MAX_BURST = MAX_BURST_DFLT
) (
   input  logic                 clk,
   input  logic                 rst_f,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      lock,
   input  logic [NREQ*DW-1:0]   data_in,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      ack,
   output logic [DW-1:0]        bus_data,
   output logic [SRC_W-1:0]     bus_src,
   output logic                 bus_valid,
   input  logic                 bus_ready
);

   arb_state_e        state, state_nxt;
   logic [SRC_W-1:0]  ptr, ptr_nxt;
   logic [BCNT_W-1:0] bcnt, bcnt_nxt;
   logic [NREQ-1:0]   gnt_nxt;
   logic [SRC_W-1:0]  src_nxt;
   logic              valid_nxt;
   dsel_e             dsel;

   logic              hs;
   logic              owner_hold;
   logic              burst_ok;
   logic              burst_cont;
   logic              burst_cut;
   logic              others;
   logic [NREQ-1:0]   pick_req;
   logic [SRC_W-1:0]  pick_ptr;
   logic              any;
   logic [SRC_W-1:0]  win;
   logic [NREQ-1:0]   win_oh;
   logic [DW-1:0]     win_data;
   logic [DW-1:0]     own_data;
   logic [DW-1:0]     data_nxt;

   // Handshake and burst decisions, all based on the registered owner.
   assign hs         = bus_valid & bus_ready;
   assign owner_hold = lock[bus_src] & req[bus_src];
   assign burst_ok   = bcnt < BCNT_W'(MAX_BURST);
   assign burst_cont = hs & owner_hold & burst_ok;
   assign burst_cut  = hs & owner_hold & ~burst_ok;
   assign others     = |(req & ~gnt);

   // A cut burst yields to any other requester; a lone one may be re-granted.
   assign pick_req = (burst_cut & others) ? (req & ~gnt) : req;
   assign pick_ptr = (state == BUSY) ? next_idx(bus_src) : ptr;

   rr_priority_pick u_pick (
      .req    (pick_req),
      .ptr    (pick_ptr),
      .any    (any),
      .winner (win)
   );

   assign win_oh = NREQ'(1) << win;

   // First level: requester data by picker winner and by current owner.
   mux4 #(.W(DW)) u_mux_win (
      .d0  (data_in[0*DW +: DW]),
      .d1  (data_in[1*DW +: DW]),
      .d2  (data_in[2*DW +: DW]),
      .d3  (data_in[3*DW +: DW]),
      .sel (win),
      .y   (win_data)
   );

   mux4 #(.W(DW)) u_mux_own (
      .d0  (data_in[0*DW +: DW]),
      .d1  (data_in[1*DW +: DW]),
      .d2  (data_in[2*DW +: DW]),
      .d3  (data_in[3*DW +: DW]),
      .sel (bus_src),
      .y   (own_data)
   );

   // Second level: hold, burst-continue or new-winner data.
   mux4 #(.W(DW)) u_mux_bus (
      .d0  (bus_data),
      .d1  (own_data),
      .d2  (win_data),
      .d3  (bus_data),
      .sel (dsel),
      .y   (data_nxt)
   );

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any) state_nxt = BUSY;
         BUSY:    if (hs && !burst_cont && !any) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt   = gnt;
      src_nxt   = bus_src;
      valid_nxt = bus_valid;
      bcnt_nxt  = bcnt;
      ptr_nxt   = ptr;
      dsel      = DSEL_HOLD;
      case (state)
         IDLE: begin
            if (any) begin
               gnt_nxt   = win_oh;
               src_nxt   = win;
               valid_nxt = 1'b1;
               bcnt_nxt  = BCNT_W'(1);
               dsel      = DSEL_WIN;
            end
         end
         BUSY: begin
            if (hs) begin
               ptr_nxt = next_idx(bus_src);
               if (burst_cont) begin
                  bcnt_nxt = bcnt + BCNT_W'(1);
                  dsel     = DSEL_OWNER;
               end else if (any) begin
                  gnt_nxt  = win_oh;
                  src_nxt  = win;
                  bcnt_nxt = BCNT_W'(1);
                  dsel     = DSEL_WIN;
               end else begin
                  gnt_nxt   = '0;
                  valid_nxt = 1'b0;
                  bcnt_nxt  = '0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         gnt       <= '0;
         bus_src   <= '0;
         bus_data  <= '0;
         bus_valid <= 1'b0;
         ptr       <= '0;
         bcnt      <= '0;
      end else begin
         gnt       <= gnt_nxt;
         bus_src   <= src_nxt;
         bus_data  <= data_nxt;
         bus_valid <= valid_nxt;
         ptr       <= ptr_nxt;
         bcnt      <= bcnt_nxt;
      end
   end

   // Accept pulse goes to the owner in the handshake cycle only.
   assign ack = hs ? gnt : '0;

endmodule
